// File: rtl/uart_echo_host.sv
// UART echo-link initiator: sends one 8N1 byte, waits for the echoed reply,
// and checks it against the responder's transform rule.
`timescale 1ns/1ps
module uart_echo_host #(
    parameter int CLK_DIV      = 326,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       rxd,
    output logic       txd,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       match,
    output logic       timeout,
    output logic       frame_err
);
    localparam int TOUT = TIMEOUT_BITS * 16;
    localparam int TW   = $clog2(TOUT + 1);

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX_START, RX_DATA, RX_STOP, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]   div_cnt;
    logic          tick;
    logic          rx_s1, rx_s2, rx_d, fall;
    logic [9:0]    frame;
    logic          tx_active;
    logic [3:0]    tcnt, bidx, rcnt;
    logic [2:0]    bcnt;
    logic [TW-1:0] tout_cnt;
    logic [7:0]    rx_sh, expected, pend_byte, acc_byte;
    logic          pend, accept, tx_end, tout_end, rx_mid, rx_full;

    assign tick = (div_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 16'd1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end
    assign fall = rx_d & ~rx_s2;

    // A start landing in the done cycle is held and taken once back in IDLE.
    assign accept   = (state == IDLE) && (start || pend);
    assign acc_byte = start ? tx_byte : pend_byte;
    assign tx_end   = tick && tx_active && (tcnt == 4'd15) && (bidx == 4'd9);
    assign tout_end = tick && (tout_cnt == TW'(1));
    assign rx_mid   = tick && (rcnt == 4'd7);
    assign rx_full  = tick && (rcnt == 4'd15);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = TX;
            TX:       if (tx_end) state_nxt = WAIT;
            WAIT:     if (fall) state_nxt = RX_START;
                      else if (tout_end) state_nxt = DONE;
            RX_START: if (rx_mid) state_nxt = rx_s2 ? WAIT : RX_DATA;
            RX_DATA:  if (rx_full && bcnt == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (rx_full) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            txd       <= 1'b1;
            frame     <= '1;
            tx_active <= 1'b0;
            tcnt      <= '0;
            bidx      <= '0;
            tout_cnt  <= '0;
            rcnt      <= '0;
            bcnt      <= '0;
            rx_sh     <= '0;
            expected  <= '0;
            pend      <= 1'b0;
            pend_byte <= '0;
            rx_byte   <= '0;
            match     <= 1'b0;
            timeout   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == DONE && start) begin
                pend      <= 1'b1;
                pend_byte <= tx_byte;
            end
            case (state)
                IDLE: if (accept) begin
                    pend      <= 1'b0;
                    frame     <= {1'b1, acc_byte, 1'b0};
                    expected  <= acc_byte[7] ? (~acc_byte | 8'h80) : acc_byte;
                    tx_active <= 1'b0;
                    match     <= 1'b0;
                    timeout   <= 1'b0;
                    frame_err <= 1'b0;
                end
                TX: if (tick) begin
                    if (!tx_active) begin
                        tx_active <= 1'b1;
                        txd       <= frame[0];
                        tcnt      <= '0;
                        bidx      <= '0;
                    end else if (tcnt == 4'd15) begin
                        tcnt <= '0;
                        if (bidx == 4'd9) begin
                            tx_active <= 1'b0;
                            tout_cnt  <= TW'(TOUT);
                        end else begin
                            bidx  <= bidx + 4'd1;
                            txd   <= frame[1];
                            frame <= {1'b1, frame[9:1]};
                        end
                    end else begin
                        tcnt <= tcnt + 4'd1;
                    end
                end
                // Counter is only touched here, so it stays frozen while RX_START vets an edge.
                WAIT: if (fall) begin
                    rcnt <= '0;
                end else if (tick) begin
                    tout_cnt <= tout_cnt - TW'(1);
                    if (tout_end) timeout <= 1'b1;
                end
                RX_START: if (tick) begin
                    rcnt <= rx_mid ? 4'd0 : rcnt + 4'd1;
                    bcnt <= '0;
                end
                RX_DATA: if (tick) begin
                    rcnt <= rcnt + 4'd1;
                    if (rx_full) begin
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                        bcnt  <= bcnt + 3'd1;
                    end
                end
                RX_STOP: if (tick) begin
                    rcnt <= rcnt + 4'd1;
                    if (rx_full) begin
                        rx_byte   <= rx_sh;
                        frame_err <= ~rx_s2;
                        match     <= (rx_sh == expected) && rx_s2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
endmodule
